// File: rtl/victim_fill_initiator_pkg.sv
// Shared types for the L2-side victim fill initiator.
package victim_fill_initiator_pkg;

  localparam int VICTIM_OFFSET_W = 4;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } victim_init_state_t;

endpackage

// File: rtl/victim_fill_initiator_sat_counter.sv
// Width-parameterised saturating event counter with synchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count up on inc and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/victim_fill_initiator.sv
// L2-side engine: on a miss, optionally pushes the evicted line into the
// victim cache, then fetches the missing line through it and hands the
// fill back to L2 with a one-cycle pulse.
//
//   state | meaning
//   IDLE  | waiting for miss_req; only state with busy=0
//   EVICT | v_write of the latched victim line until v_resp
//   FETCH | v_read of the missing line until v_resp
//   RESP  | fill_valid pulse, fill_data holds the captured line
import victim_fill_initiator_pkg::*;

module victim_fill_initiator #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = VICTIM_OFFSET_W,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              evict_valid,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  output logic              busy,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic [ADDR_W-1:0] v_address,
  output logic [LINE_W-1:0] v_wdata,
  output logic              v_read,
  output logic              v_write,
  input  logic [LINE_W-1:0] v_rdata,
  input  logic              v_resp,
  output logic [CNT_W-1:0]  evict_count,
  output logic [CNT_W-1:0]  fill_count
);

  // Clears the offset bits so the victim cache always sees line addresses.
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  victim_init_state_t state, state_nxt;

  logic [ADDR_W-1:0] miss_line_q;
  logic [ADDR_W-1:0] evict_line_q;
  logic [LINE_W-1:0] evict_data_q;
  logic              evict_inc;
  logic              fill_inc;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch on acceptance and fill capture on the fetch response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_line_q  <= '0;
      evict_line_q <= '0;
      evict_data_q <= '0;
      fill_data    <= '0;
    end else begin
      if ((state == IDLE) && miss_req) begin
        miss_line_q  <= miss_addr & LINE_MASK;
        evict_line_q <= evict_addr & LINE_MASK;
        evict_data_q <= evict_data;
      end
      if (fill_inc) begin
        fill_data <= v_rdata;
      end
    end
  end

  // Next-state and victim port decode; outputs depend only on state and latches.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    fill_valid = 1'b0;
    v_read     = 1'b0;
    v_write    = 1'b0;
    v_address  = '0;
    v_wdata    = '0;
    evict_inc  = 1'b0;
    fill_inc   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (miss_req) begin
          state_nxt = evict_valid ? EVICT : FETCH;
        end
      end
      EVICT: begin
        v_write   = 1'b1;
        v_address = evict_line_q;
        v_wdata   = evict_data_q;
        if (v_resp) begin
          evict_inc = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        v_read    = 1'b1;
        v_address = miss_line_q;
        if (v_resp) begin
          fill_inc  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        fill_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_evict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (evict_inc),
    .count (evict_count)
  );

  sat_counter #(.W(CNT_W)) u_fill_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fill_inc),
    .count (fill_count)
  );

endmodule

// File: tb/tb_victim_fill_initiator.sv
// Directed plus randomized bench for victim_fill_initiator. The victim cache
// is modelled as a table of lines written by evicts; misses in the table
// return a synthetic memory pattern.
module tb_victim_fill_initiator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req;
  logic [15:0]  miss_addr;
  logic         evict_valid;
  logic [15:0]  evict_addr;
  logic [127:0] evict_data;
  logic         busy;
  logic         fill_valid;
  logic [127:0] fill_data;
  logic [15:0]  v_address;
  logic [127:0] v_wdata;
  logic         v_read;
  logic         v_write;
  logic [127:0] v_rdata;
  logic         v_resp;
  logic [15:0]  evict_count;
  logic [15:0]  fill_count;

  int checks = 0;
  int failures = 0;

  logic [127:0] vt [logic [15:0]];
  logic [15:0]  m_ev_cnt;
  logic [15:0]  m_fill_cnt;
  logic [127:0] m_fill_data;

  victim_fill_initiator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .evict_valid (evict_valid),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .busy        (busy),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .v_address   (v_address),
    .v_wdata     (v_wdata),
    .v_read      (v_read),
    .v_write     (v_write),
    .v_rdata     (v_rdata),
    .v_resp      (v_resp),
    .evict_count (evict_count),
    .fill_count  (fill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] line_of(input logic [15:0] a);
    return a & 16'hFFF0;
  endfunction

  function automatic logic [127:0] lookup(input logic [15:0] a);
    if (vt.exists(line_of(a))) return vt[line_of(a)];
    return {8{line_of(a) ^ 16'hC3C3}};
  endfunction

  // One full transaction; called at a negedge with the DUT idle.
  task automatic run_txn(input logic [15:0] ma, input logic ev, input logic [15:0] ea,
                         input logic [127:0] ed, input int ew, input int fw,
                         input logic [127:0] rd, input logic noisy);
    check("idle_busy", busy, 1'b0);
    miss_req = 1'b1; miss_addr = ma; evict_valid = ev; evict_addr = ea; evict_data = ed;
    v_resp = 1'b0;
    @(negedge clk);
    if (ev) begin
      for (int w = 0; w <= ew; w++) begin
        check("ev_write", v_write, 1'b1);
        check("ev_read", v_read, 1'b0);
        check("ev_addr", v_address, line_of(ea));
        check("ev_wdata", v_wdata, ed);
        check("ev_busy", busy, 1'b1);
        check("ev_fill_valid", fill_valid, 1'b0);
        miss_req = noisy ? 1'($urandom) : 1'b0;
        miss_addr = 16'($urandom); evict_valid = 1'($urandom);
        evict_addr = 16'($urandom); evict_data = {4{$urandom}};
        v_resp = (w == ew);
        v_rdata = {4{$urandom}};
        @(negedge clk);
      end
      if (m_ev_cnt != 16'hFFFF) m_ev_cnt++;
    end
    for (int w = 0; w <= fw; w++) begin
      check("fe_read", v_read, 1'b1);
      check("fe_write", v_write, 1'b0);
      check("fe_addr", v_address, line_of(ma));
      check("fe_busy", busy, 1'b1);
      check("fe_fill_valid", fill_valid, 1'b0);
      check("fe_evict_count", evict_count, m_ev_cnt);
      miss_req = noisy ? 1'($urandom) : 1'b0;
      miss_addr = 16'($urandom); evict_valid = 1'($urandom);
      v_resp = (w == fw);
      v_rdata = (w == fw) ? rd : {4{$urandom}};
      @(negedge clk);
    end
    if (m_fill_cnt != 16'hFFFF) m_fill_cnt++;
    m_fill_data = rd;
    check("resp_fill_valid", fill_valid, 1'b1);
    check("resp_fill_data", fill_data, rd);
    check("resp_fill_count", fill_count, m_fill_cnt);
    check("resp_evict_count", evict_count, m_ev_cnt);
    check("resp_read", v_read, 1'b0);
    check("resp_write", v_write, 1'b0);
    check("resp_busy", busy, 1'b1);
    miss_req = noisy ? 1'($urandom) : 1'b0;
    v_resp = 1'($urandom);
    v_rdata = {4{$urandom}};
    @(negedge clk);
    check("post_fill_valid", fill_valid, 1'b0);
    check("post_busy", busy, 1'b0);
    check("post_fill_data", fill_data, m_fill_data);
    check("post_rw", {v_read, v_write}, 2'b00);
    check("post_fill_count", fill_count, m_fill_cnt);
    miss_req = 1'b0;
    v_resp = 1'($urandom);
    @(negedge clk);
    check("idle_fill_count", fill_count, m_fill_cnt);
    check("idle_evict_count", evict_count, m_ev_cnt);
    check("idle_busy2", busy, 1'b0);
    v_resp = 1'b0;
  endtask

  initial begin
    logic [15:0]  ma, ea;
    logic [127:0] ed, rd;
    logic         ev;

    rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; evict_valid = 1'b0;
    evict_addr = '0; evict_data = '0; v_rdata = '0; v_resp = 1'b0;
    m_ev_cnt = '0; m_fill_cnt = '0; m_fill_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_rw", {v_read, v_write}, 2'b00);
    check("rst_fill_data", fill_data, 128'h0);
    check("rst_wdata", v_wdata, 128'h0);
    check("rst_addr", v_address, 16'h0);
    check("rst_counts", {evict_count, fill_count}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain fetch, responder two cycles late.
    run_txn(16'h1234, 1'b0, 16'h0, 128'h0, 0, 2, {16{8'hA5}}, 1'b0);
    check("t1_fill_count", fill_count, 16'd1);

    // Evict then fetch, zero-wait responder.
    ed = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0011_2233, 16'hBEEF};
    vt[line_of(16'h4020)] = ed;
    run_txn(16'h8000, 1'b1, 16'h4020, ed, 0, 0, lookup(16'h8000), 1'b0);
    check("t2_evict_count", evict_count, 16'd1);

    // Evicted line equals the missing line: fetch must return the evicted data.
    ed = {4{$urandom}};
    vt[line_of(16'h0100)] = ed;
    rd = lookup(16'h0100);
    check("t3_model_hit", rd, ed);
    run_txn(16'h0100, 1'b1, 16'h0100, ed, 1, 1, rd, 1'b0);

    // Requests pulsed while busy must be ignored.
    run_txn(16'h5550, 1'b0, 16'h0, 128'h0, 2, 3, lookup(16'h5550), 1'b1);
    ed = {4{$urandom}};
    vt[line_of(16'h6660)] = ed;
    run_txn(16'h7777, 1'b1, 16'h6660, ed, 2, 2, lookup(16'h7777), 1'b1);

    // Randomized traffic against the table model.
    for (int n = 0; n < 40; n++) begin
      ma = {2'b00, 2'($urandom), 8'h00, 4'($urandom)};
      ea = {2'b00, 2'($urandom), 8'h00, 4'($urandom)};
      ev = 1'($urandom);
      ed = {4{$urandom}};
      if (ev) vt[line_of(ea)] = ed;
      rd = lookup(ma);
      run_txn(ma, ev, ea, ed, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd, 1'($urandom));
    end

    // Reset in the middle of a fetch; a late response must be ignored.
    miss_req = 1'b1; miss_addr = 16'h2468; evict_valid = 1'b0;
    @(negedge clk);
    miss_req = 1'b0;
    check("mid_read", v_read, 1'b1);
    @(negedge clk);
    check("mid_read2", v_read, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    m_ev_cnt = '0; m_fill_cnt = '0; m_fill_data = '0;
    check("mid_rst_read", v_read, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_fill_valid", fill_valid, 1'b0);
    check("mid_rst_counts", {evict_count, fill_count}, 32'h0);
    rst_n = 1'b1; v_resp = 1'b1; v_rdata = {4{$urandom}};
    @(negedge clk);
    check("late_busy", busy, 1'b0);
    check("late_fill_valid", fill_valid, 1'b0);
    check("late_fill_data", fill_data, 128'h0);
    v_resp = 1'b0;
    @(negedge clk);
    check("late_fill_valid2", fill_valid, 1'b0);
    check("late_counts", {evict_count, fill_count}, 32'h0);

    // Counter saturation from a preloaded near-max value.
    force dut.u_fill_cnt.count = 16'hFFFD;
    force dut.u_evict_cnt.count = 16'hFFFE;
    @(negedge clk);
    release dut.u_fill_cnt.count;
    release dut.u_evict_cnt.count;
    m_fill_cnt = 16'hFFFD; m_ev_cnt = 16'hFFFE;
    @(negedge clk);
    check("preload_fill", fill_count, m_fill_cnt);
    for (int n = 0; n < 3; n++) begin
      ma = 16'h3000 + 16'(n * 16);
      ed = {4{$urandom}};
      vt[line_of(ma)] = ed;
      run_txn(ma, 1'b1, ma, ed, 0, 0, lookup(ma), 1'b0);
    end
    check("sat_fill", fill_count, 16'hFFFF);
    check("sat_evict", evict_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
